// File: rtl/tonomat_pkg.sv
// Shared types and constants for the multi-product vending controller.
package tonomat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int unsigned COIN_1  = 1;
  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;

endpackage

// File: rtl/tonomat_change.sv
// Greedy change emitter: pays a loaded amount as one R5/R1 pulse per cycle.
// The first pulse is registered on the load edge; done marks the last pulse.
module tonomat_change
  import tonomat_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] amount,
  output logic         R1,
  output logic         R5,
  output logic         done
);

  logic [W-1:0] amt_q;
  logic [W-1:0] amt_src;
  logic [W-1:0] amt_n;
  logic         r1_n;
  logic         r5_n;
  logic         done_n;

  always_comb begin
    amt_src = load ? amount : amt_q;
    amt_n   = amt_src;
    r1_n    = 1'b0;
    r5_n    = 1'b0;
    if (amt_src >= W'(COIN_5)) begin
      r5_n  = 1'b1;
      amt_n = amt_src - W'(COIN_5);
    end else if (amt_src != '0) begin
      r1_n  = 1'b1;
      amt_n = amt_src - W'(COIN_1);
    end
    done_n = (r1_n | r5_n) && (amt_n == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      amt_q <= '0;
      R1    <= 1'b0;
      R5    <= 1'b0;
      done  <= 1'b0;
    end else begin
      amt_q <= amt_n;
      R1    <= r1_n;
      R5    <= r5_n;
      done  <= done_n;
    end
  end

endmodule

// File: rtl/tonomat_multi.sv
// Multi-product vending controller: coin credit, priced vend, serial change.
// Define TONOMAT_MULTIVEND_EN to keep leftover credit after a vend (change only on CANCEL).
module tonomat_multi
  import tonomat_pkg::*;
#(
  parameter int unsigned                    N_PROD     = 4,
  parameter int unsigned                    CREDIT_W   = 8,
  parameter logic [N_PROD*CREDIT_W-1:0]     PRICES     = {8'd12, 8'd7, 8'd5, 8'd3},
  parameter int unsigned                    MAX_CREDIT = 50,
  parameter int unsigned                    SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RON1,
  input  logic                RON5,
  input  logic                RON10,
  input  logic [SEL_W-1:0]    SEL,
  input  logic                BUY,
  input  logic                CANCEL,
  output logic                PRODUS,
  output logic [SEL_W-1:0]    PROD_ID,
  output logic                R1,
  output logic                R5,
  output logic                REJ,
  output logic                DENY,
  output logic                BUSY,
  output logic [CREDIT_W-1:0] CREDIT
);

  state_t              state_q, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [SEL_W-1:0]    prod_id_n;
  logic                produs_n, rej_n, deny_n, busy_n;
  logic                load;
  logic [CREDIT_W-1:0] load_amt;
  logic                change_done;

  logic [CREDIT_W-1:0] price_sel;
  logic                sel_ok;
  logic [1:0]          n_coins;
  logic                any_coin;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;

  // Price lookup; indices beyond N_PROD leave sel_ok low.
  always_comb begin
    price_sel = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < int'(N_PROD); i++) begin
      if (SEL == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  // Coin decode: a single coin is accepted only if it keeps credit within MAX_CREDIT.
  always_comb begin
    n_coins  = 2'(RON1) + 2'(RON5) + 2'(RON10);
    any_coin = RON1 | RON5 | RON10;
    coin_val = RON10 ? CREDIT_W'(COIN_10) : (RON5 ? CREDIT_W'(COIN_5) : CREDIT_W'(COIN_1));
    coin_sum = {1'b0, CREDIT} + {1'b0, coin_val};
    coin_ok  = (n_coins == 2'd1) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  end

  always_comb begin
    state_n   = state_q;
    credit_n  = CREDIT;
    prod_id_n = PROD_ID;
    produs_n  = 1'b0;
    rej_n     = 1'b0;
    deny_n    = 1'b0;
    load      = 1'b0;
    load_amt  = CREDIT;
    unique case (state_q)
      IDLE: begin
        if (CANCEL && CREDIT != '0) begin
          state_n = CHANGE;
          load    = 1'b1;
          rej_n   = any_coin;
        end else if (BUY && !CANCEL && sel_ok && CREDIT >= price_sel) begin
          state_n   = VEND;
          credit_n  = CREDIT - price_sel;
          prod_id_n = SEL;
          produs_n  = 1'b1;
          rej_n     = any_coin;
        end else begin
          // Reaching here with BUY and no CANCEL means the purchase was refused.
          deny_n = BUY && !CANCEL;
          if (coin_ok) credit_n = coin_sum[CREDIT_W-1:0];
          else         rej_n    = any_coin;
        end
      end
      VEND: begin
        rej_n = any_coin;
`ifdef TONOMAT_MULTIVEND_EN
        state_n = IDLE;
`else
        if (CREDIT != '0) begin
          state_n = CHANGE;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
        end
`endif
      end
      CHANGE: begin
        rej_n    = any_coin;
        credit_n = CREDIT - (R5 ? CREDIT_W'(COIN_5) : '0) - (R1 ? CREDIT_W'(COIN_1) : '0);
        if (change_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      CREDIT  <= '0;
      PROD_ID <= '0;
      PRODUS  <= 1'b0;
      REJ     <= 1'b0;
      DENY    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_n;
      CREDIT  <= credit_n;
      PROD_ID <= prod_id_n;
      PRODUS  <= produs_n;
      REJ     <= rej_n;
      DENY    <= deny_n;
      BUSY    <= busy_n;
    end
  end

  tonomat_change #(.W(CREDIT_W)) u_change (
    .CLK    (CLK),
    .RESET  (RESET),
    .load   (load),
    .amount (load_amt),
    .R1     (R1),
    .R5     (R5),
    .done   (change_done)
  );

endmodule

// File: tb/tb_tonomat_multi.sv
// Scoreboard bench for tonomat_multi: per-cycle expected outputs queued with stimulus.
module tb_tonomat_multi;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       RON1 = 1'b0, RON5 = 1'b0, RON10 = 1'b0;
  logic [1:0] SEL = '0;
  logic       BUY = 1'b0, CANCEL = 1'b0;
  logic       PRODUS;
  logic [1:0] PROD_ID;
  logic       R1, R5, REJ, DENY, BUSY;
  logic [7:0] CREDIT;

  always #5 CLK = ~CLK;

  tonomat_multi dut (
    .CLK(CLK), .RESET(RESET), .RON1(RON1), .RON5(RON5), .RON10(RON10),
    .SEL(SEL), .BUY(BUY), .CANCEL(CANCEL), .PRODUS(PRODUS), .PROD_ID(PROD_ID),
    .R1(R1), .R5(R5), .REJ(REJ), .DENY(DENY), .BUSY(BUSY), .CREDIT(CREDIT)
  );

  typedef struct packed {
    logic       ron1, ron5, ron10;
    logic [1:0] sel;
    logic       buy, cancel, rst;
  } in_t;

  // cv=0 leaves CREDIT unchecked in VEND/CHANGE cycles.
  typedef struct packed {
    logic       produs;
    logic [1:0] pid;
    logic       r1, r5, rej, deny, busy, cv;
    logic [7:0] credit;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  string scen = "reset";

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s/%s cyc=%0d: got %0d expected %0d", scen, tag, cyc, got, want);
    end
  endtask

  function automatic in_t ci(bit r1, bit r5, bit r10, int sel, bit buy, bit cancel, bit rst);
    in_t i;
    i.ron1 = r1; i.ron5 = r5; i.ron10 = r10; i.sel = 2'(sel);
    i.buy = buy; i.cancel = cancel; i.rst = rst;
    return i;
  endfunction

  function automatic exp_t ex(bit produs, int pid, bit r1, bit r5, bit rej, bit deny,
                              bit busy, bit cv, int credit);
    exp_t e;
    e.produs = produs; e.pid = 2'(pid); e.r1 = r1; e.r5 = r5; e.rej = rej;
    e.deny = deny; e.busy = busy; e.cv = cv; e.credit = 8'(credit);
    return e;
  endfunction

  function automatic exp_t idle(int credit, bit rej = 1'b0, bit deny = 1'b0);
    return ex(1'b0, 0, 1'b0, 1'b0, rej, deny, 1'b0, 1'b1, credit);
  endfunction

  function automatic exp_t chg(bit r1, bit r5, bit rej = 1'b0);
    return ex(1'b0, 0, r1, r5, rej, 1'b0, 1'b1, 1'b0, 0);
  endfunction

  function automatic exp_t vend(int pid, bit rej = 1'b0);
    return ex(1'b1, pid, 1'b0, 1'b0, rej, 1'b0, 1'b1, 1'b0, 0);
  endfunction

  task automatic tick(input in_t i, input exp_t e);
    exp_t x;
    @(negedge CLK);
    RON1 = i.ron1; RON5 = i.ron5; RON10 = i.ron10; SEL = i.sel;
    BUY = i.buy; CANCEL = i.cancel; RESET = i.rst;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    cyc++;
    x = exp_q.pop_front();
    check("PRODUS", int'(PRODUS), int'(x.produs));
    if (x.produs) check("PROD_ID", int'(PROD_ID), int'(x.pid));
    check("R1", int'(R1), int'(x.r1));
    check("R5", int'(R5), int'(x.r5));
    check("REJ", int'(REJ), int'(x.rej));
    check("DENY", int'(DENY), int'(x.deny));
    check("BUSY", int'(BUSY), int'(x.busy));
    if (x.cv) check("CREDIT", int'(CREDIT), int'(x.credit));
  endtask

  in_t NONE;

  initial begin
    NONE = '0;

    scen = "reset";
    tick(ci(0,0,0,0,0,0,1), idle(0));
    tick(ci(0,0,0,0,0,0,1), idle(0));
    tick(NONE, idle(0));

    scen = "exact_pay";
    tick(ci(0,0,1,0,0,0,0), idle(10));
    tick(ci(1,0,0,0,0,0,0), idle(11));
    tick(ci(1,0,0,0,0,0,0), idle(12));
    tick(ci(0,0,0,3,1,0,0), vend(3));
    tick(NONE, idle(0));
    tick(NONE, idle(0));

    scen = "vend_change";
    tick(ci(0,0,1,0,0,0,0), idle(10));
    tick(ci(0,0,0,0,1,0,0), vend(0));
`ifdef TONOMAT_MULTIVEND_EN
    tick(NONE, idle(7));
    tick(NONE, idle(7));
    tick(ci(0,0,0,0,0,1,0), chg(0,1));
`else
    tick(NONE, chg(0,1));
`endif
    tick(NONE, chg(1,0));
    tick(NONE, chg(1,0));
    tick(NONE, idle(0));

    scen = "deny_cancel";
    tick(ci(0,1,0,0,0,0,0), idle(5));
    tick(ci(0,0,0,2,1,0,0), idle(5, 0, 1));
    tick(ci(0,0,0,0,0,1,0), chg(0,1));
    tick(NONE, idle(0));
    tick(ci(0,0,0,0,0,1,0), idle(0));
    tick(ci(0,0,1,3,1,0,0), idle(10, 0, 1));
    tick(ci(0,0,0,0,0,1,0), chg(0,1));
    tick(NONE, chg(0,1));
    tick(NONE, idle(0));

    scen = "max_credit";
    for (int k = 1; k <= 5; k++) tick(ci(0,0,1,0,0,0,0), idle(10*k));
    tick(ci(1,0,0,0,0,0,0), idle(50, 1));
    tick(ci(0,1,0,0,0,0,0), idle(50, 1));
    tick(ci(0,0,0,0,0,1,0), chg(0,1));
    for (int k = 0; k < 9; k++) tick(NONE, chg(0,1));
    tick(NONE, idle(0));
    tick(ci(1,1,0,0,0,0,0), idle(0, 1));
    tick(ci(1,1,1,0,0,0,0), idle(0, 1));

    scen = "coin_in_vend";
    tick(ci(0,1,0,0,0,0,0), idle(5));
    tick(ci(1,0,0,1,1,0,0), vend(1, 1));
    tick(NONE, idle(0));

    scen = "coin_in_change";
    tick(ci(0,0,1,0,0,0,0), idle(10));
    tick(ci(0,0,0,0,0,1,0), chg(0,1));
    tick(ci(1,0,0,0,0,0,0), chg(0,1,1));
    tick(NONE, idle(0));

    scen = "buy_cancel";
    tick(ci(0,1,0,0,0,0,0), idle(5));
    tick(ci(1,0,0,0,0,0,0), idle(6));
    tick(ci(0,0,0,0,1,1,0), chg(0,1));
    tick(NONE, chg(1,0));
    tick(NONE, idle(0));
    tick(ci(0,0,0,0,1,1,0), idle(0));

    scen = "reset_in_change";
    tick(ci(0,0,1,0,0,0,0), idle(10));
    tick(ci(0,1,0,0,0,0,0), idle(15));
    tick(ci(0,0,0,0,0,1,0), chg(0,1));
    tick(NONE, chg(0,1));
    tick(ci(0,0,0,0,0,0,1), idle(0));
    tick(NONE, idle(0));
    tick(NONE, idle(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
